// File: rtl/motor_fault_supervisor_pkg.sv
// Shared types and helpers for the motor fault supervisor: FSM state
// encoding, fault-code values and small saturating/encoding functions.
`timescale 1ns/1ps
package motor_fault_supervisor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TRIPPED = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_OC    = 2'b01;
  localparam logic [1:0] FC_STALL = 2'b10;
  localparam logic [1:0] FC_BOTH  = 2'b11;

  // Map the {stall, oc} flag pair of a sample onto the reported fault code.
  function automatic logic [1:0] fault_code_of(input logic [1:0] flags);
    logic [1:0] code;
    case (flags)
      2'b00:   code = FC_NONE;
      2'b01:   code = FC_OC;
      2'b10:   code = FC_STALL;
      2'b11:   code = FC_BOTH;
      default: code = FC_NONE;
    endcase
    return code;
  endfunction

  // 8-bit increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/motor_fault_supervisor_fault_debounce.sv
// Saturating consecutive-bad-sample counter. Any good sample or a clear
// returns the count to zero; hit is asserted while the count sits at DEBOUNCE.
`timescale 1ns/1ps
module fault_debounce #(
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic bad,
  input  logic clr,
  output logic hit
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] CNT_MAX  = DW'(DEBOUNCE);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);
  localparam logic [DW-1:0] CNT_ZERO = DW'(0);

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  // Next count: clear wins, bad samples climb to the ceiling, good samples reset.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (bad) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == CNT_MAX);

endmodule

// File: rtl/motor_fault_supervisor.sv
// Motor enable sequencer: runs the motor, trips on debounced over-current or
// stall, cools down, retries a bounded number of times and then locks out
// until explicitly cleared. The trip acts on the registered debounce count,
// so motor_en falls DEBOUNCE+1 edges after the first bad sample is taken.
`timescale 1ns/1ps
module motor_fault_supervisor
  import motor_fault_supervisor_pkg::*;
#(
  parameter logic [15:0] OC_THRESH   = 16'd3000,
  parameter logic [15:0] STALL_SPEED = 16'd100,
  parameter int unsigned DEBOUNCE    = 8,
  parameter int unsigned BLANK_CYC   = 200,
  parameter int unsigned COOLDOWN    = 1000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_cmd,
  input  logic        stop_cmd,
  input  logic        clear_lockout,
  input  logic [15:0] current_in,
  input  logic [15:0] speed_in,
  output logic        motor_en,
  output logic        fault_detected,
  output logic [1:0]  fault_code,
  output logic        lockout,
  output logic [7:0]  retry_cnt
);

  localparam int unsigned BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam int unsigned CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYC);
  localparam logic [BW-1:0] BLANK_ONE  = BW'(1);
  localparam logic [BW-1:0] BLANK_ZERO = BW'(0);
  localparam logic [CW-1:0] COOL_LOAD  = CW'(COOLDOWN);
  localparam logic [CW-1:0] COOL_ONE   = CW'(1);
  localparam logic [CW-1:0] COOL_ZERO  = CW'(0);
  localparam logic [7:0]    RETRY_LIM  = 8'(MAX_RETRY);

  state_e        state_q, state_d;
  logic          motor_en_q, motor_en_d;
  logic          fault_detected_q, fault_detected_d;
  logic [1:0]    fault_code_q, fault_code_d;
  logic          lockout_q, lockout_d;
  logic [7:0]    retry_cnt_q, retry_cnt_d;
  logic [BW-1:0] blank_q, blank_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [1:0]    sample_flags_q, sample_flags_d;

  logic oc_s;
  logic stall_s;
  logic bad_s;
  logic clr_s;
  logic hit_s;

  // Per-sample fault classification; stall is masked during spin-up blanking.
  always_comb begin
    oc_s           = (current_in > OC_THRESH);
    stall_s        = (state_q == ST_RUN) && (blank_q == BLANK_ZERO) && (speed_in < STALL_SPEED);
    bad_s          = (state_q == ST_RUN) && (oc_s || stall_s);
    clr_s          = (state_q != ST_RUN);
    sample_flags_d = {stall_s, oc_s};
  end

  fault_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_fault_debounce (
    .clk (clk),
    .rst (rst),
    .bad (bad_s),
    .clr (clr_s),
    .hit (hit_s)
  );

  // FSM next state and next values of every registered output and counter.
  always_comb begin
    state_d          = state_q;
    motor_en_d       = motor_en_q;
    fault_detected_d = fault_detected_q;
    fault_code_d     = fault_code_q;
    lockout_d        = lockout_q;
    retry_cnt_d      = retry_cnt_q;
    blank_d          = blank_q;
    cool_d           = cool_q;
    case (state_q)
      ST_IDLE: begin
        motor_en_d       = 1'b0;
        fault_detected_d = 1'b0;
        lockout_d        = 1'b0;
        if (stop_cmd) begin
          fault_code_d = FC_NONE;
        end else if (start_cmd) begin
          state_d      = ST_RUN;
          motor_en_d   = 1'b1;
          blank_d      = BLANK_LOAD;
          retry_cnt_d  = 8'd0;
          fault_code_d = FC_NONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop_cmd) begin
          state_d          = ST_IDLE;
          motor_en_d       = 1'b0;
          fault_detected_d = 1'b0;
          fault_code_d     = FC_NONE;
          lockout_d        = 1'b0;
        end else if (hit_s) begin
          // Code comes from the sample that completed the debounce run.
          state_d          = ST_TRIPPED;
          motor_en_d       = 1'b0;
          fault_detected_d = 1'b1;
          fault_code_d     = fault_code_of(sample_flags_q);
          retry_cnt_d      = sat_inc8(retry_cnt_q);
          cool_d           = COOL_LOAD;
        end else if (blank_q != BLANK_ZERO) begin
          blank_d = blank_q - BLANK_ONE;
        end else begin
          blank_d = BLANK_ZERO;
        end
      end
      ST_TRIPPED: begin
        if (stop_cmd) begin
          state_d          = ST_IDLE;
          motor_en_d       = 1'b0;
          fault_detected_d = 1'b0;
          fault_code_d     = FC_NONE;
          lockout_d        = 1'b0;
          cool_d           = COOL_ZERO;
        end else if (cool_q <= COOL_ONE) begin
          cool_d = COOL_ZERO;
          if (retry_cnt_q > RETRY_LIM) begin
            state_d          = ST_LOCKOUT;
            motor_en_d       = 1'b0;
            fault_detected_d = 1'b1;
            lockout_d        = 1'b1;
          end else begin
            state_d          = ST_RUN;
            motor_en_d       = 1'b1;
            fault_detected_d = 1'b0;
            blank_d          = BLANK_LOAD;
          end
        end else begin
          cool_d = cool_q - COOL_ONE;
        end
      end
      ST_LOCKOUT: begin
        if (clear_lockout) begin
          state_d          = ST_IDLE;
          motor_en_d       = 1'b0;
          fault_detected_d = 1'b0;
          fault_code_d     = FC_NONE;
          lockout_d        = 1'b0;
          retry_cnt_d      = 8'd0;
        end else begin
          motor_en_d       = 1'b0;
          fault_detected_d = 1'b1;
          lockout_d        = 1'b1;
        end
      end
      default: begin
        state_d          = ST_IDLE;
        motor_en_d       = 1'b0;
        fault_detected_d = 1'b0;
        fault_code_d     = FC_NONE;
        lockout_d        = 1'b0;
        retry_cnt_d      = 8'd0;
        blank_d          = BLANK_ZERO;
        cool_d           = COOL_ZERO;
      end
    endcase
  end

  // State, counter and output registers; reset drops motor_en asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      motor_en_q       <= 1'b0;
      fault_detected_q <= 1'b0;
      fault_code_q     <= FC_NONE;
      lockout_q        <= 1'b0;
      retry_cnt_q      <= 8'd0;
      blank_q          <= BLANK_ZERO;
      cool_q           <= COOL_ZERO;
      sample_flags_q   <= 2'b00;
    end else begin
      state_q          <= state_d;
      motor_en_q       <= motor_en_d;
      fault_detected_q <= fault_detected_d;
      fault_code_q     <= fault_code_d;
      lockout_q        <= lockout_d;
      retry_cnt_q      <= retry_cnt_d;
      blank_q          <= blank_d;
      cool_q           <= cool_d;
      sample_flags_q   <= sample_flags_d;
    end
  end

  assign motor_en       = motor_en_q;
  assign fault_detected = fault_detected_q;
  assign fault_code     = fault_code_q;
  assign lockout        = lockout_q;
  assign retry_cnt      = retry_cnt_q;

endmodule

// File: tb/tb_motor_fault_supervisor.sv
// Directed bench for motor_fault_supervisor. Expected output snapshots are
// queued as stimulus is applied and compared once the DUT has clocked them.
`timescale 1ns/1ps
module tb_motor_fault_supervisor;

  logic        clk;
  logic        rst;
  logic        start_cmd;
  logic        stop_cmd;
  logic        clear_lockout;
  logic [15:0] current_in;
  logic [15:0] speed_in;
  logic        motor_en;
  logic        fault_detected;
  logic [1:0]  fault_code;
  logic        lockout;
  logic [7:0]  retry_cnt;

  typedef struct packed {
    logic       en;
    logic       fd;
    logic [1:0] code;
    logic       lo;
    logic [7:0] rc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks;
  int    n_fail;

  motor_fault_supervisor dut (
    .clk            (clk),
    .rst            (rst),
    .start_cmd      (start_cmd),
    .stop_cmd       (stop_cmd),
    .clear_lockout  (clear_lockout),
    .current_in     (current_in),
    .speed_in       (speed_in),
    .motor_en       (motor_en),
    .fault_detected (fault_detected),
    .fault_code     (fault_code),
    .lockout        (lockout),
    .retry_cnt      (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cmp(input string tag, input string field, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic en, input logic fd, input logic [1:0] code,
                      input logic lo, input logic [7:0] rc);
    exp_t e;
    e.en = en; e.fd = fd; e.code = code; e.lo = lo; e.rc = rc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp(t, "motor_en",       8'(motor_en),       8'(e.en));
    cmp(t, "fault_detected", 8'(fault_detected), 8'(e.fd));
    cmp(t, "fault_code",     8'(fault_code),     8'(e.code));
    cmp(t, "lockout",        8'(lockout),        8'(e.lo));
    cmp(t, "retry_cnt",      retry_cnt,          e.rc);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start_cmd = 1'b0;
    stop_cmd = 1'b0;
    clear_lockout = 1'b0;
    current_in = 16'd1980;
    speed_in = 16'd1500;
    repeat (2) @(negedge clk);
    push("reset", 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
    check_out();
    rst = 1'b0;
    push("idle_after_reset", 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
    tick();
    check_out();

    // 1: healthy run
    start_cmd = 1'b1;
    push("t1_start", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    tick();
    start_cmd = 1'b0;
    check_out();
    for (int i = 0; i < 5000; i++) begin
      tick();
      cmp("t1_run", "motor_en", 8'(motor_en), 8'd1);
      cmp("t1_run", "fault_detected", 8'(fault_detected), 8'd0);
    end

    // 2: over-current trip, cooldown, retry, threshold boundary
    current_in = 16'd3500;
    push("t2_pre_trip", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    cycles(8);
    check_out();
    push("t2_trip", 1'b0, 1'b1, 2'b01, 1'b0, 8'd1);
    tick();
    check_out();
    current_in = 16'd1980;
    push("t2_cooldown", 1'b0, 1'b1, 2'b01, 1'b0, 8'd1);
    cycles(999);
    check_out();
    push("t2_retry", 1'b1, 1'b0, 2'b01, 1'b0, 8'd1);
    tick();
    check_out();
    current_in = 16'd3000;
    push("t2_at_thresh", 1'b1, 1'b0, 2'b01, 1'b0, 8'd1);
    cycles(50);
    check_out();
    stop_cmd = 1'b1;
    push("t2_stop", 1'b0, 1'b0, 2'b00, 1'b0, 8'd1);
    tick();
    stop_cmd = 1'b0;
    check_out();

    // 3: glitch rejection
    current_in = 16'd1980;
    start_cmd = 1'b1;
    push("t3_start", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    tick();
    start_cmd = 1'b0;
    check_out();
    current_in = 16'd3500;
    cycles(7);
    current_in = 16'd1980;
    tick();
    current_in = 16'd3500;
    cycles(7);
    current_in = 16'd1980;
    push("t3_glitch", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    cycles(4);
    check_out();
    stop_cmd = 1'b1;
    push("t3_stop", 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
    tick();
    stop_cmd = 1'b0;
    check_out();

    // 4: stall blanking then stall trip
    speed_in = 16'd0;
    start_cmd = 1'b1;
    push("t4_start", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    tick();
    start_cmd = 1'b0;
    check_out();
    push("t4_blanking", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    cycles(200);
    check_out();
    push("t4_pre_trip", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    cycles(8);
    check_out();
    push("t4_trip", 1'b0, 1'b1, 2'b10, 1'b0, 8'd1);
    tick();
    check_out();
    stop_cmd = 1'b1;
    push("t4_stop", 1'b0, 1'b0, 2'b00, 1'b0, 8'd1);
    tick();
    stop_cmd = 1'b0;
    check_out();
    speed_in = 16'd1500;

    // 5: repeated trips into lockout, then clear
    current_in = 16'd3500;
    start_cmd = 1'b1;
    push("t5_start", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    tick();
    start_cmd = 1'b0;
    check_out();
    for (int k = 1; k <= 4; k++) begin
      push($sformatf("t5_pre_trip%0d", k), 1'b1, 1'b0, (k == 1) ? 2'b00 : 2'b01, 1'b0, 8'(k - 1));
      cycles(8);
      check_out();
      push($sformatf("t5_trip%0d", k), 1'b0, 1'b1, 2'b01, 1'b0, 8'(k));
      tick();
      check_out();
      push($sformatf("t5_cool%0d", k), 1'b0, 1'b1, 2'b01, 1'b0, 8'(k));
      cycles(999);
      check_out();
      if (k < 4) begin
        push($sformatf("t5_retry%0d", k), 1'b1, 1'b0, 2'b01, 1'b0, 8'(k));
      end else begin
        push("t5_lockout", 1'b0, 1'b1, 2'b01, 1'b1, 8'd4);
      end
      tick();
      check_out();
    end
    start_cmd = 1'b1;
    stop_cmd = 1'b1;
    push("t5_ignore_cmds", 1'b0, 1'b1, 2'b01, 1'b1, 8'd4);
    tick();
    start_cmd = 1'b0;
    stop_cmd = 1'b0;
    check_out();
    clear_lockout = 1'b1;
    push("t5_clear", 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
    tick();
    clear_lockout = 1'b0;
    check_out();
    current_in = 16'd1980;

    // 6a: asynchronous reset between clock edges
    start_cmd = 1'b1;
    push("t6_start", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    tick();
    start_cmd = 1'b0;
    check_out();
    cycles(3);
    #2;
    rst = 1'b1;
    #1;
    push("t6_async_rst", 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
    check_out();
    @(negedge clk);
    rst = 1'b0;
    push("t6_after_rst", 1'b0, 1'b0, 2'b00, 1'b0, 8'd0);
    tick();
    check_out();

    // 6b: stop on the same cycle a trip would fire
    current_in = 16'd3500;
    start_cmd = 1'b1;
    push("t6b_start", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    tick();
    start_cmd = 1'b0;
    check_out();
    push("t6b_pre_trip", 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    cycles(8);
    check_out();
    push("t6b_trip", 1'b0, 1'b1, 2'b01, 1'b0, 8'd1);
    tick();
    check_out();
    push("t6b_retry", 1'b1, 1'b0, 2'b01, 1'b0, 8'd1);
    cycles(1000);
    check_out();
    push("t6b_pre_trip2", 1'b1, 1'b0, 2'b01, 1'b0, 8'd1);
    cycles(8);
    check_out();
    stop_cmd = 1'b1;
    push("t6b_stop_vs_trip", 1'b0, 1'b0, 2'b00, 1'b0, 8'd1);
    tick();
    stop_cmd = 1'b0;
    check_out();
    push("t6b_idle_hold", 1'b0, 1'b0, 2'b00, 1'b0, 8'd1);
    cycles(12);
    check_out();
    current_in = 16'd1980;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
